sram_like_slave: RTL
====================

# sram_like_slave

Responder end of the `data_sram` request/address/data-handshake interface that the EXE/MEM stages drive. It accepts one request per cycle via `req`/`addr_ok`, performs byte-strobed writes or word reads on an internal word-addressed memory, and returns in-order `data_ok` (plus `rdata` for reads) after a fixed latency. It is the stand-in data memory for CPU-level simulation, and it also serves as the model behind future AXI bridges. A stall input injects address-phase backpressure so the initiator's `mem_handled` and stall paths get exercised.

## Interface
- `AW`, 12: word-address bits; the memory holds 2^AW 32-bit words.
- `DEPTH`, 2: maximum outstanding accepted requests awaiting `data_ok` (≥1).
- `LAT`, 2: cycles from the acceptance edge to `data_ok` (≥1).

- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 byte, 1 half, 2 word. Informational only; reads always return the full word.
- `wstrb`  in  4  write byte-lane enables; ignored for reads.
- `addr`  in  32  byte address. Bits [AW+1:2] select the word; all other bits are ignored, so addresses alias.
- `wdata`  in  32  write data, already lane-replicated by the initiator.
- `stall_in`  in  1  1 forces `addr_ok` low in the same cycle.
- `addr_ok`  out  1  request accepted at this edge if `req` is also high.
- `data_ok`  out  1  one-cycle pulse per accepted request, in acceptance order.
- `rdata`  out  32  read word when `data_ok` is high and the head entry is a read; 0 otherwise.

## Operation
- Acceptance = `req & addr_ok` at a rising edge. `addr_ok = ~stall_in & (count < DEPTH)`.
  - `addr_ok` does not depend on `req`.
  - There is no same-cycle bypass: when `count == DEPTH`, `addr_ok` stays low even if a pop happens that cycle.
- Write acceptance:
  - Each byte lane i of `mem[addr[AW+1:2]]` with `wstrb[i]=1` takes `wdata[8i+7:8i]` at the acceptance edge.
  - A queue entry {wr=1, data=0} is pushed.
- Read acceptance: `mem[addr[AW+1:2]]` is sampled at the acceptance edge, after any earlier write, and pushed as {wr=0, data}.
  - Read-after-write on consecutive cycles therefore returns the new data.
- Queue:
  - In-order, `DEPTH` entries. Each entry carries a countdown loaded with LAT−1.
  - All non-zero countdowns decrement every cycle in parallel.
  - The head entry with countdown 0 drives `data_ok`/`rdata` for that cycle and pops at the following edge.
- The initiator is always ready for responses; `data_ok` has no backpressure.
- `count` is $clog2(DEPTH+1) bits wide.
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (async, any time, including mid-transaction):
  - Queue emptied, `count`=0, `data_ok`=0, `rdata`=0.
  - Outstanding requests are discarded and never receive `data_ok`.
  - `addr_ok` is forced low while `reset` is high.
  - Memory contents are not reset.

## Timing
- `addr_ok`: combinational from `count` and `stall_in`.
- `data_ok`, `rdata`: registered outputs. Reset values are 0.
- Accept at edge t → `data_ok` high during the cycle after edge t+LAT−1 (LAT=1: the cycle immediately after acceptance).
- Throughput is one request per cycle while `count < DEPTH`. With DEPTH=2, LAT=2, back-to-back accepts fill the queue and `addr_ok` drops for one cycle.
- A `stall_in` held high for N cycles with `req` high yields exactly N cycles of `addr_ok=0` and no acceptance.

## Structure
- Package `sram_like_pkg`:
  - `SIZE_B`/`SIZE_H`/`SIZE_W` constants.
  - `resp_entry_t` = {wr, data[31:0], cnt}.
- Sub-module `sram_like_resp_queue`: the in-order countdown FIFO, exposing push, pop, head-ready and count.
- The top level holds the memory array, the strobed-write logic and the `addr_ok` generation.

## Test plan
- Reset, then write 0x12345678 to 0x100 with wstrb 1111, then read 0x100 → `data_ok` two cycles after each acceptance; read `rdata`=0x12345678.
- Write 0xAABBCCDD to 0x100 with wstrb 0100, then read → `rdata`=0x12BB5678.
- Issue 4 back-to-back reads with `req` held high (DEPTH=2, LAT=2) → `addr_ok` pattern 1,1,0,1,1; four `data_ok` pulses in order; no pulse lost.
- Hold `stall_in`=1 for 3 cycles with `req` high → `addr_ok`=0 for 3 cycles; acceptance on the 4th; `data_ok` LAT cycles later.
- Assert `reset` one cycle after two accepts → `data_ok` never rises for them; `count`=0 afterwards; the next request is accepted immediately.
- Write to 0x4000_0100 with AW=12, then read 0x100 → aliased value returned.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared constants and the response-queue entry type for the SRAM-like data port.
package sram_like_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Countdown field width; LAT must not exceed 2**TMR_W.
  localparam int TMR_W = 8;

  typedef struct packed {
    logic             wr;
    logic [31:0]      data;
    logic [TMR_W-1:0] cnt;
  } resp_entry_t;

endpackage

// File: rtl/sram_like_slave_resp_queue.sv
// In-order response FIFO; each entry counts down from LAT-1 and the head
// is presented (registered) once its countdown has reached zero.
module sram_like_resp_queue #(
  parameter int DEPTH = 2,
  parameter int LAT   = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_wr,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output logic             head_ready,
  output logic [31:0]      head_rdata,
  output logic [CNT_W-1:0] count
);
  import sram_like_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      ent_r      [DEPTH];
  resp_entry_t      ent_nxt_s  [DEPTH];
  resp_entry_t      head_nxt_s;
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             head_ready_r, head_ready_nxt_s;
  logic [31:0]      head_rdata_r, head_rdata_nxt_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = {PTR_W{1'b0}};
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  // Next queue state; the head flags are derived from it so they can be registered.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt_s[i] = ent_r[i];
      if (ent_r[i].cnt != {TMR_W{1'b0}}) ent_nxt_s[i].cnt = ent_r[i].cnt - TMR_W'(1);
      else                               ent_nxt_s[i].cnt = ent_r[i].cnt;
    end
    if (push) ent_nxt_s[wr_ptr_r] = '{wr: push_wr, data: push_data, cnt: TMR_W'(LAT - 1)};
    else      ent_nxt_s[wr_ptr_r] = ent_nxt_s[wr_ptr_r];

    if (pop) rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    else     rd_ptr_nxt_s = rd_ptr_r;
    if (push) wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    else      wr_ptr_nxt_s = wr_ptr_r;

    case ({push, pop})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase

    head_nxt_s       = ent_nxt_s[rd_ptr_nxt_s];
    head_ready_nxt_s = (count_nxt_s != {CNT_W{1'b0}}) && (head_nxt_s.cnt == {TMR_W{1'b0}});
    if (head_ready_nxt_s && !head_nxt_s.wr) head_rdata_nxt_s = head_nxt_s.data;
    else                                    head_rdata_nxt_s = 32'h0000_0000;
  end

  // Queue storage, pointers and registered head outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_r[i] <= '{wr: 1'b0, data: 32'h0, cnt: {TMR_W{1'b0}}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      head_ready_r <= 1'b0;
      head_rdata_r <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_r[i] <= ent_nxt_s[i];
      rd_ptr_r     <= rd_ptr_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      count_r      <= count_nxt_s;
      head_ready_r <= head_ready_nxt_s;
      head_rdata_r <= head_rdata_nxt_s;
    end
  end

  assign head_ready = head_ready_r;
  assign head_rdata = head_rdata_r;
  assign count      = count_r;

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like data-port responder: word memory with byte-strobed writes and
// fixed-latency in-order responses through the countdown queue.
module sram_like_slave #(
  parameter int AW    = 12,
  parameter int DEPTH = 2,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall_in,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  import sram_like_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_r [0:(1 << AW) - 1];
  logic [AW-1:0]    word_s;
  logic             accept_s;
  logic [31:0]      push_data_s;
  logic             head_ready_s;
  logic [CNT_W-1:0] count_s;
  logic             unused_s;

  // Byte-lane select and access size carry no meaning for this word memory.
  assign unused_s = ^{size, addr[31:AW+2], addr[1:0]};

  assign word_s   = addr[AW+1:2];
  assign addr_ok  = ~reset & ~stall_in & (count_s < CNT_W'(DEPTH));
  assign accept_s = req & addr_ok;

  // Reads see every write accepted at an earlier edge.
  assign push_data_s = wr ? 32'h0000_0000 : mem_r[word_s];

  // Strobed write; memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept_s && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_r[word_s][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  sram_like_resp_queue #(
    .DEPTH (DEPTH),
    .LAT   (LAT),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (accept_s),
    .push_wr    (wr),
    .push_data  (push_data_s),
    .pop        (head_ready_s),
    .head_ready (head_ready_s),
    .head_rdata (rdata),
    .count      (count_s)
  );

  assign data_ok = head_ready_s;

endmodule
